ysyx_cdb_arbiter: RTL and testbench
===================================

YSYX_CDB_ARBITER -- requirements
Module: ysyx_cdb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning result/npc width.
REQ-002 SHALL have parameter NREQ, default 3, meaning number of execution-unit requesters (0=ALU, 1=LSU, 2=MUL); legal range 2..8.
REQ-003 SHALL have parameter DEST_W, default 4, meaning ROB tag width; tag = ROB index + 1, tag 0 = no destination.
REQ-004 SHALL have port clock  input  1  clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  pipeline flush from ROB commit.
REQ-007 SHALL have port req_valid  input  NREQ  per-requester result valid.
REQ-008 SHALL have port req_ready  output  NREQ  per-requester grant/accept.
REQ-009 SHALL have port req_dest  input  NREQ*DEST_W  per-requester ROB tag, requester i at bits [i*DEST_W +: DEST_W].
REQ-010 SHALL have port req_result  input  NREQ*XLEN  per-requester result.
REQ-011 SHALL have port req_npc  input  NREQ*XLEN  per-requester next PC.
REQ-012 SHALL have port req_pc_change  input  NREQ  per-requester redirect flag.
REQ-013 SHALL have port cdb_valid  output  1  broadcast valid.
REQ-014 SHALL have port cdb_ready  input  1  ROB/IQ accepts broadcast.
REQ-015 SHALL have ports cdb_dest (DEST_W), cdb_result (XLEN), cdb_npc (XLEN), cdb_pc_change (1), all outputs: broadcast payload.
REQ-016 SHALL have port cdb_src  output  $clog2(NREQ)  index of granted requester.
REQ-017 SHALL have port stall_cnt  output  32  count of cycles with >=1 req_valid and no transfer.

Function
REQ-018 SHALL hold one output register (slot); slot is free when !cdb_valid or (cdb_valid && cdb_ready).
REQ-019 SHALL assert exactly one req_ready bit, combinationally, only when the slot is free, flush=0, and that requester is the round-robin winner; all other bits 0.
REQ-020 SHALL choose the winner as the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ (wrap-around at NREQ-1 -> 0).
REQ-021 SHALL on transfer (req_valid[i] && req_ready[i]) set rr_ptr <= (i+1) mod NREQ; rr_ptr unchanged otherwise.
REQ-022 SHALL load the slot with requester i's payload and cdb_src=i on the cycle after transfer (latency 1), cdb_valid=1.
REQ-023 SHALL keep cdb_valid and all payload stable while cdb_valid && !cdb_ready.
REQ-024 SHALL, when the slot drains (cdb_ready=1) and a new transfer occurs the same cycle, present the new payload next cycle with no bubble (full throughput, 1 result/cycle).
REQ-025 SHALL clear cdb_valid at the end of the slot-drain cycle when no new transfer occurs.
REQ-026 SHALL accept a request with dest tag 0 (req_ready per REQ-019) but not load the slot; cdb_valid stays 0 for it; rr_ptr advances per REQ-021.
REQ-027 SHALL on flush=1: drive req_ready=0, set cdb_valid <= 0 (slot discarded regardless of cdb_ready); rr_ptr retained; flush has priority over any transfer.
REQ-028 SHALL increment stall_cnt when any req_valid=1, flush=0, and no transfer occurs; saturate at 32'hFFFF_FFFF; unaffected by flush cycles.
REQ-029 SHALL require requesters to hold req_valid and payload until accepted; arbiter behaviour on a dropped request is not defined.

Reset
REQ-030 SHALL on reset (synchronous, active-high, priority over flush): cdb_valid=0, cdb_dest=0, cdb_result=0, cdb_npc=0, cdb_pc_change=0, cdb_src=0, rr_ptr=0, stall_cnt=0.
REQ-031 SHALL drive req_ready=0 during reset; reset asserted mid-stall discards the held slot.

Verification
REQ-032 Single: reset, req_valid=3'b001, dest=3, result=32'hDEAD_BEEF, cdb_ready=1 -> req_ready[0]=1 cycle 0; cdb_valid=1, cdb_dest=3, cdb_result=32'hDEAD_BEEF, cdb_src=0 cycle 1.
REQ-033 Round-robin: all three req_valid=1 held, cdb_ready=1 -> grants 0,1,2,0 on consecutive cycles; cdb_src 0,1,2,0 one cycle later, no bubbles.
REQ-034 Backpressure: slot holds dest=5, cdb_ready=0 for 4 cycles with req_valid=3'b010 -> req_ready=0, payload stable, stall_cnt +4; cdb_ready=1 -> requester 1 granted that cycle, cdb_src=1 next cycle.
REQ-035 Flush: cdb_valid=1 dest=2, cdb_ready=0, req_valid=3'b100, flush=1 -> req_ready=0; next cycle cdb_valid=0, rr_ptr unchanged, stall_cnt unchanged.
REQ-036 Dest 0: req_valid=3'b001 dest=0 -> req_ready[0]=1, next cycle cdb_valid=0, rr_ptr=1.
REQ-037 Reset mid-stall: cdb_valid=1, cdb_ready=0, stall_cnt=7, reset=1 one cycle -> all outputs 0, rr_ptr=0.

Source files
------------

// File: rtl/ysyx_cdb_arbiter.sv
// Round-robin arbiter that funnels execution-unit results onto one registered
// common data bus slot, with ready/valid backpressure, flush and stall counting.

module ysyx_cdb_arbiter_lane #(
  parameter int XLEN   = 32,
  parameter int DEST_W = 4,
  parameter int PAY_W  = DEST_W + 2 * XLEN + 1
) (
  input  logic              grant,
  input  logic [DEST_W-1:0] dest,
  input  logic [XLEN-1:0]   result,
  input  logic [XLEN-1:0]   npc,
  input  logic              pc_change,
  output logic [PAY_W-1:0]  pay
);
  // Non-granted lanes contribute zero so the top can OR-reduce instead of muxing.
  assign pay = grant ? {dest, result, npc, pc_change} : '0;
endmodule

module ysyx_cdb_arbiter #(
  parameter int XLEN   = 32,
  parameter int NREQ   = 3,
  parameter int DEST_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DEST_W-1:0]   req_dest,
  input  logic [NREQ*XLEN-1:0]     req_result,
  input  logic [NREQ*XLEN-1:0]     req_npc,
  input  logic [NREQ-1:0]          req_pc_change,
  output logic                     cdb_valid,
  input  logic                     cdb_ready,
  output logic [DEST_W-1:0]        cdb_dest,
  output logic [XLEN-1:0]          cdb_result,
  output logic [XLEN-1:0]          cdb_npc,
  output logic                     cdb_pc_change,
  output logic [$clog2(NREQ)-1:0]  cdb_src,
  output logic [31:0]              stall_cnt
);
  localparam int SRC_W = $clog2(NREQ);
  localparam int PAY_W = DEST_W + 2 * XLEN + 1;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   npc;
    logic              pc_change;
  } payload_t;

  logic [SRC_W-1:0]            rr_ptr, win, win_next, idx;
  logic                        found, slot_free, grant_en, xfer, any_valid;
  logic [NREQ-1:0]             grant;
  logic [NREQ-1:0][PAY_W-1:0]  lane_pay;
  logic [PAY_W-1:0]            sel_pay;
  payload_t                    sel, slot;
  int                          sum;

  assign slot_free = !cdb_valid || cdb_ready;
  assign grant_en  = slot_free && !flush && !reset;
  assign any_valid = |req_valid;

  // First valid requester at or after rr_ptr, wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = 0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = (int'(rr_ptr) + k) % NREQ;
      idx = SRC_W'(sum);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_en && found) grant[win] = 1'b1;
  end

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);
  assign win_next  = (win == SRC_W'(NREQ - 1)) ? '0 : win + 1'b1;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    ysyx_cdb_arbiter_lane #(.XLEN(XLEN), .DEST_W(DEST_W), .PAY_W(PAY_W)) u_lane (
      .grant     (grant[i]),
      .dest      (req_dest[i*DEST_W +: DEST_W]),
      .result    (req_result[i*XLEN +: XLEN]),
      .npc       (req_npc[i*XLEN +: XLEN]),
      .pc_change (req_pc_change[i]),
      .pay       (lane_pay[i])
    );
  end

  always_comb begin
    sel_pay = '0;
    for (int i = 0; i < NREQ; i++) sel_pay = sel_pay | lane_pay[i];
  end

  assign sel = payload_t'(sel_pay);

  // A transfer can only happen with the slot free, so an accepted tag-0 request
  // simply lets the slot drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      slot      <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else begin
      if (xfer) rr_ptr <= win_next;
      if (xfer && sel.dest != '0) begin
        cdb_valid <= 1'b1;
        slot      <= sel;
        cdb_src   <= win;
      end else if (cdb_ready) begin
        cdb_valid <= 1'b0;
      end
      if (any_valid && !xfer && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign cdb_dest      = slot.dest;
  assign cdb_result    = slot.result;
  assign cdb_npc       = slot.npc;
  assign cdb_pc_change = slot.pc_change;

endmodule

// File: tb/tb_ysyx_cdb_arbiter.sv
// Directed bench for ysyx_cdb_arbiter (XLEN=32, NREQ=3, DEST_W=4).
module tb_ysyx_cdb_arbiter;
  logic        clock = 1'b0;
  logic        reset, flush, cdb_ready;
  logic [2:0]  req_valid, req_pc_change, req_ready;
  logic [3:0]  d [3];
  logic [31:0] r [3];
  logic [31:0] n [3];
  logic [11:0] req_dest;
  logic [95:0] req_result, req_npc;
  logic        cdb_valid, cdb_pc_change;
  logic [3:0]  cdb_dest;
  logic [31:0] cdb_result, cdb_npc, stall_cnt;
  logic [1:0]  cdb_src;
  int          tests = 0;
  int          fails = 0;

  assign req_dest   = {d[2], d[1], d[0]};
  assign req_result = {r[2], r[1], r[0]};
  assign req_npc    = {n[2], n[1], n[0]};

  always #5 clock = ~clock;

  ysyx_cdb_arbiter #(.XLEN(32), .NREQ(3), .DEST_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
    .req_result(req_result), .req_npc(req_npc), .req_pc_change(req_pc_change),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_dest(cdb_dest),
    .cdb_result(cdb_result), .cdb_npc(cdb_npc), .cdb_pc_change(cdb_pc_change),
    .cdb_src(cdb_src), .stall_cnt(stall_cnt)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic probe;
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; cdb_ready = 1'b0;
    req_valid = 3'b001; req_pc_change = 3'b000;
    for (int i = 0; i < 3; i++) begin d[i] = '0; r[i] = '0; n[i] = '0; end

    // reset
    probe; chk("rst_ready", req_ready, 0);
    tick; tick;
    reset = 1'b0; req_valid = 3'b000;
    probe;
    chk("rst_valid", cdb_valid, 0);
    chk("rst_dest", cdb_dest, 0);
    chk("rst_result", cdb_result, 0);
    chk("rst_src", cdb_src, 0);
    chk("rst_stall", stall_cnt, 0);

    // single transfer
    tick;
    req_valid = 3'b001; d[0] = 4'd3; r[0] = 32'hDEAD_BEEF; n[0] = 32'h8000_0004;
    req_pc_change = 3'b001; cdb_ready = 1'b1;
    probe; chk("single_ready", req_ready, 3'b001);
    tick; req_valid = 3'b000; req_pc_change = 3'b000;
    probe;
    chk("single_valid", cdb_valid, 1);
    chk("single_dest", cdb_dest, 3);
    chk("single_result", cdb_result, 32'hDEAD_BEEF);
    chk("single_npc", cdb_npc, 32'h8000_0004);
    chk("single_pcc", cdb_pc_change, 1);
    chk("single_src", cdb_src, 0);
    chk("single_idle_ready", req_ready, 0);
    tick; probe;
    chk("single_drain", cdb_valid, 0);
    chk("single_stall", stall_cnt, 0);

    // round robin, full throughput
    reset = 1'b1; tick; reset = 1'b0;
    d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3;
    r[0] = 32'h111; r[1] = 32'h222; r[2] = 32'h333;
    req_valid = 3'b111; cdb_ready = 1'b1;
    probe; chk("rr_g0", req_ready, 3'b001);
    tick; probe;
    chk("rr_g1", req_ready, 3'b010); chk("rr_s0", cdb_src, 0); chk("rr_d0", cdb_dest, 1);
    tick; probe;
    chk("rr_g2", req_ready, 3'b100); chk("rr_s1", cdb_src, 1); chk("rr_d1", cdb_dest, 2);
    tick; probe;
    chk("rr_g3", req_ready, 3'b001); chk("rr_s2", cdb_src, 2); chk("rr_r2", cdb_result, 32'h333);
    tick; req_valid = 3'b000; probe;
    chk("rr_s3", cdb_src, 0); chk("rr_v3", cdb_valid, 1); chk("rr_d3", cdb_dest, 1);
    chk("rr_stall", stall_cnt, 0);

    // backpressure
    tick;
    req_valid = 3'b010; d[1] = 4'd5; r[1] = 32'h555; cdb_ready = 1'b0;
    probe; chk("bp_grant", req_ready, 3'b010);
    tick; d[1] = 4'd6; r[1] = 32'h666;
    for (int k = 0; k < 4; k++) begin
      probe;
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_dest", cdb_dest, 5);
      chk("bp_hold_result", cdb_result, 32'h555);
      chk("bp_hold_valid", cdb_valid, 1);
      tick;
    end
    cdb_ready = 1'b1;
    probe; chk("bp_stall", stall_cnt, 4); chk("bp_regrant", req_ready, 3'b010);
    tick; req_valid = 3'b000;
    probe;
    chk("bp_src", cdb_src, 1); chk("bp_dest", cdb_dest, 6);
    chk("bp_valid", cdb_valid, 1); chk("bp_stall_after", stall_cnt, 4);

    // flush
    tick;
    req_valid = 3'b100; d[2] = 4'd2; r[2] = 32'hF00D; cdb_ready = 1'b0;
    probe; chk("fl_grant", req_ready, 3'b100);
    tick; d[2] = 4'd7; flush = 1'b1;
    probe; chk("fl_pre_valid", cdb_valid, 1); chk("fl_pre_dest", cdb_dest, 2);
    chk("fl_ready", req_ready, 0);
    tick; flush = 1'b0; req_valid = 3'b000;
    probe; chk("fl_valid", cdb_valid, 0); chk("fl_stall", stall_cnt, 4);
    req_valid = 3'b111; cdb_ready = 1'b1; #1;
    chk("fl_ptr", req_ready, 3'b001);
    req_valid = 3'b000;

    // tag 0 accepted but not broadcast
    tick; req_valid = 3'b001; d[0] = 4'd0;
    probe; chk("d0_ready", req_ready, 3'b001);
    tick; req_valid = 3'b000;
    probe; chk("d0_valid", cdb_valid, 0);
    req_valid = 3'b111; #1;
    chk("d0_ptr", req_ready, 3'b010);
    req_valid = 3'b000;

    // reset mid-stall
    tick; req_valid = 3'b001; d[0] = 4'd9; r[0] = 32'h9999; cdb_ready = 1'b0;
    probe; chk("ms_grant", req_ready, 3'b001);
    tick; d[0] = 4'd10;
    tick; tick; tick;
    probe; chk("ms_stall", stall_cnt, 7); chk("ms_valid_pre", cdb_valid, 1);
    chk("ms_dest_pre", cdb_dest, 9);
    tick; reset = 1'b1;
    probe; chk("ms_rst_ready", req_ready, 0);
    tick; reset = 1'b0; req_valid = 3'b000;
    probe;
    chk("ms_valid", cdb_valid, 0); chk("ms_dest", cdb_dest, 0);
    chk("ms_result", cdb_result, 0); chk("ms_npc", cdb_npc, 0);
    chk("ms_src", cdb_src, 0); chk("ms_stall_clr", stall_cnt, 0);
    req_valid = 3'b111; cdb_ready = 1'b1; #1;
    chk("ms_ptr", req_ready, 3'b001);
    req_valid = 3'b000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
